button_conditioner: RTL
=======================

# button_conditioner

Conditions the raw Basys3 push-buttons (btnU, btnC, btnD) before they reach the OLED/LED student stages. Per button it synchronises, debounces against a shared 1 kHz sample tick, and emits a stable level plus single-cycle press/release pulses. A press pulse repeats automatically while the button is held. Downstream stages increment state once per press pulse instead of once per clock while held. A stage-enable input (driven by the password_X unlock signals) gates all pulses.

## Interface
- N_BTN, 3: number of independent button channels (bit 0 = btnU, 1 = btnC, 2 = btnD).
- SAMPLE_DIV, 100000: clock_100mhz cycles per sample tick (1 kHz).
- DEBOUNCE_TICKS, 20: consecutive agreeing ticks required to change a debounced level.
- REPEAT_DELAY_TICKS, 500: hold time from the first press pulse to the first auto-repeat pulse.
- REPEAT_PERIOD_TICKS, 150: interval between successive auto-repeat pulses.
- REPEAT_EN, 1: 0 disables auto-repeat (HOLD is then terminal until release).

- clock_100mhz, in, 1: system clock.
- reset, in, 1: asynchronous, active-high; clears all state.
- enable, in, 1: stage unlock; pulses are suppressed while low.
- btn_raw, in, N_BTN: asynchronous raw button inputs.
- btn_level, out, N_BTN: debounced level; independent of enable.
- btn_press, out, N_BTN: one-cycle pulse on debounced press and on each auto-repeat.
- btn_release, out, N_BTN: one-cycle pulse on debounced release.

## Operation
- Each btn_raw bit passes through a 2-flop synchroniser, giving sync[i].
- Prescaler: counts 0..SAMPLE_DIV-1 and asserts tick for one cycle when it wraps. One prescaler is shared by all channels.
- Debounce, per channel, evaluated only on tick:
  - If sync equals level, stable_cnt clears to 0.
  - Otherwise stable_cnt increments. When it reaches DEBOUNCE_TICKS-1, level toggles and stable_cnt clears.
- Channel FSM, per channel, with hold_cnt counting ticks:
  - RELEASED: on a level rise with enable=1, assert press, clear hold_cnt, go to HOLD_DELAY.
  - HOLD_DELAY: on each tick, hold_cnt increments. When hold_cnt reaches REPEAT_DELAY_TICKS-1 and REPEAT_EN=1: assert press, clear hold_cnt, go to HOLD_REPEAT.
  - HOLD_REPEAT: when hold_cnt reaches REPEAT_PERIOD_TICKS-1: assert press and clear hold_cnt.
  - From HOLD_DELAY or HOLD_REPEAT, a level fall asserts release and returns to RELEASED.
  - WAIT_RELEASE: entered when enable rises while level=1. Produces no pulses. A level fall returns to RELEASED with no release pulse.
- enable=0: all channels are forced to RELEASED with hold_cnt=0, and btn_press and btn_release are held at 0. Debounce and btn_level continue to run.
- Channels are fully independent. Several press or release bits may assert in the same cycle.
- Counter widths are $clog2 of their terminal value, with a minimum of 1 bit. No counter wraps past its terminal value.

## Timing
- Reset values: btn_level=0, btn_press=0, btn_release=0. Synchroniser flops, prescaler, stable_cnt and hold_cnt are 0. All FSMs are in RELEASED.
- Outputs are registered. The press or release pulse asserts in the same cycle btn_level changes, which is always the cycle after a tick.
- Press latency from a clean raw edge: 2 synchroniser cycles, plus up to SAMPLE_DIV cycles of tick alignment, plus DEBOUNCE_TICKS ticks, plus 1 cycle.
- A bounce, i.e. sync returning to level before the count completes, restarts the debounce count. A burst shorter than DEBOUNCE_TICKS ticks produces no output.
- Simultaneous enable fall and level change: enable wins, so no pulse is emitted.
- Reset asserted mid-hold: all outputs drop to 0 asynchronously. After reset deassertion, a still-held button is re-debounced from level=0 and produces a fresh press.

## Structure
- A shared package/header holds:
  - the FSM state encodings: RELEASED=2'd0, HOLD_DELAY=2'd1, HOLD_REPEAT=2'd2, WAIT_RELEASE=2'd3;
  - the default timing constants.
- The top level holds the prescaler and a generate loop over the channels.
- Sub-module button_channel holds the synchroniser, debounce counter, FSM and hold counter for one channel. It takes tick and enable as inputs.

## Test plan
All scenarios use SAMPLE_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=10, REPEAT_PERIOD_TICKS=4 and enable=1 unless stated.
- Reset, then hold btn_raw=0 for 100 cycles -> all outputs stay 0. Assert reset mid-hold -> outputs are 0 within the same cycle.
- btn_raw[0] rises cleanly and is held 20 cycles -> btn_level[0] rises within 2+4+12+1 cycles. Exactly one btn_press[0] pulse, coincident with the level rise.
- btn_raw[1] toggles every 5 cycles for 60 cycles, then settles at 1 -> no press pulse during the toggling. Exactly one press after settling.
- btn_raw[2] is held 200 cycles -> press at debounce, then after 40 more cycles, then every 16 cycles. Release -> one btn_release[2] pulse and no further press.
- Hold btn_raw[0] with enable=0, then raise enable -> btn_level[0]=1 and no pulses. Release -> no release pulse. A subsequent press -> one press pulse.
- Press btnU and btnD in the same cycle -> btn_press=3'b101 in a single cycle.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared FSM encodings, default timing constants and counter sizing for the button conditioner.
// No logic and no flow control; it only supplies types and constants.
package button_conditioner_pkg;

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] HOLD_DELAY   = 2'd1;
  localparam logic [1:0] HOLD_REPEAT  = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  localparam int unsigned DEF_N_BTN               = 3;
  localparam int unsigned DEF_SAMPLE_DIV          = 100000;
  localparam int unsigned DEF_DEBOUNCE_TICKS      = 20;
  localparam int unsigned DEF_REPEAT_DELAY_TICKS  = 500;
  localparam int unsigned DEF_REPEAT_PERIOD_TICKS = 150;
  localparam bit          DEF_REPEAT_EN           = 1'b1;

  // A counter running 0..terminal-1 never needs to hold terminal itself.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, tick-based debounce, press/auto-repeat/release FSM.
// Latency: 2 sync cycles + tick alignment + DEBOUNCE_TICKS ticks + 1 registered cycle.
// Backpressure: none; pulses are single-cycle and must be consumed when they appear.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
  parameter int unsigned REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
  parameter int unsigned REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS,
  parameter bit          REPEAT_EN           = DEF_REPEAT_EN
) (
  input  logic clock_100mhz,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned STABLE_W  = cnt_width(DEBOUNCE_TICKS);
  localparam int unsigned HOLD_TERM = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                                      REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int unsigned HOLD_W    = cnt_width(HOLD_TERM);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0]   DELAY_LAST  = HOLD_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [HOLD_W-1:0]   PERIOD_LAST = HOLD_W'(REPEAT_PERIOD_TICKS - 1);

  logic                sync_meta;
  logic                sync_q;
  logic [STABLE_W-1:0] stable_cnt;
  logic                level_q;
  logic                mismatch;
  logic                settled;
  logic                level_rise;
  logic                level_fall;
  logic [1:0]          state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                press_q;
  logic                release_q;

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  assign mismatch   = (sync_q != level_q);
  assign settled    = tick && mismatch && (stable_cnt == STABLE_LAST);
  assign level_rise = settled && !level_q;
  assign level_fall = settled && level_q;

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      level_q    <= 1'b0;
    end else if (tick) begin
      if (!mismatch) begin
        stable_cnt <= '0;
      end else if (stable_cnt == STABLE_LAST) begin
        stable_cnt <= '0;
        level_q    <= ~level_q;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  // FSM reacts to the same tick that flips level_q, so pulses line up with the level edge.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      state     <= RELEASED;
      hold_cnt  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (!enable) begin
        state    <= RELEASED;
        hold_cnt <= '0;
      end else begin
        case (state)
          RELEASED: begin
            if (level_rise) begin
              press_q  <= 1'b1;
              hold_cnt <= '0;
              state    <= HOLD_DELAY;
            end else if (level_q && !level_fall) begin
              // Only reachable right after enable rises with the button already down.
              state <= WAIT_RELEASE;
            end
          end
          HOLD_DELAY: begin
            if (level_fall) begin
              release_q <= 1'b1;
              hold_cnt  <= '0;
              state     <= RELEASED;
            end else if (tick) begin
              if (hold_cnt == DELAY_LAST) begin
                if (REPEAT_EN) begin
                  press_q  <= 1'b1;
                  hold_cnt <= '0;
                  state    <= HOLD_REPEAT;
                end
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          HOLD_REPEAT: begin
            if (level_fall) begin
              release_q <= 1'b1;
              hold_cnt  <= '0;
              state     <= RELEASED;
            end else if (tick) begin
              if (hold_cnt == PERIOD_LAST) begin
                press_q  <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          WAIT_RELEASE: begin
            if (level_fall) begin
              state <= RELEASED;
            end
          end
          default: begin
            state    <= RELEASED;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw buttons into debounced levels and gated press/release pulses.
// Latency: 2 sync cycles + up to SAMPLE_DIV cycles + DEBOUNCE_TICKS ticks + 1 cycle.
// Backpressure: none; outputs are free-running single-cycle pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN               = DEF_N_BTN,
  parameter int unsigned SAMPLE_DIV          = DEF_SAMPLE_DIV,
  parameter int unsigned DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
  parameter int unsigned REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
  parameter int unsigned REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS,
  parameter bit          REPEAT_EN           = DEF_REPEAT_EN
) (
  input  logic             clock_100mhz,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int unsigned         PRESC_W    = cnt_width(SAMPLE_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  assign tick = (presc_cnt == PRESC_LAST);

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS),
      .REPEAT_EN           (REPEAT_EN)
    ) u_chan (
      .clock_100mhz (clock_100mhz),
      .reset        (reset),
      .tick         (tick),
      .enable       (enable),
      .btn_raw      (btn_raw[i]),
      .btn_level    (btn_level[i]),
      .btn_press    (btn_press[i]),
      .btn_release  (btn_release[i])
    );
  end

endmodule
